// File: rtl/seq_chk_pkg.sv
// Shared definitions for stream sequence monitors: FSM state encoding and
// error-counter width with its saturation helper.
package seq_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_SYNC   = 2'd2,
        ST_LOCKED = 2'd3
    } seq_state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Saturating increment for the error counter.
    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] c);
        return (c == ERR_CNT_MAX) ? c : c + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rep_run_tracker.sv
// Run tracker: holds the current run value and length, judges each sample
// against the expected continuation and reports completion or violation.
// Outputs complete/violate/done_value are combinational for the sample
// presented this cycle; the FSM registers them.
module rep_run_tracker #(
    parameter int W    = 4,
    parameter int REP  = 5,
    parameter int MAXV = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic         start,
    input  logic         track,
    input  logic [W-1:0] sample,
    output logic         complete,
    output logic         violate,
    output logic [W-1:0] done_value
);

    localparam logic [3:0]   REP_L  = 4'(REP);
    localparam logic [W-1:0] MAXV_L = W'(MAXV);

    logic [W-1:0] cur;
    logic [3:0]   run_len;
    logic [W-1:0] cur_nxt;
    logic [3:0]   len_inc;
    logic         in_run;
    logic         match;

    assign cur_nxt = (cur == MAXV_L) ? '0 : cur + W'(1);
    assign len_inc = run_len + 4'd1;
    assign in_run  = (run_len < REP_L);

    // Judge the incoming sample: repeat of cur while the run is short, else the next value.
    always_comb begin
        match      = in_run ? (sample == cur) : (sample == cur_nxt);
        complete   = 1'b0;
        violate    = 1'b0;
        done_value = cur;
        if (valid) begin
            if (start) begin
                complete   = (REP_L == 4'd1);
                done_value = sample;
            end else if (track) begin
                if (!match) begin
                    violate = 1'b1;
                end else if (in_run) begin
                    complete   = (len_inc == REP_L);
                    done_value = cur;
                end else begin
                    complete   = (REP_L == 4'd1);
                    done_value = cur_nxt;
                end
            end
        end
    end

    // Advance the run registers on accepted samples; a violation drops the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '0;
            run_len <= '0;
        end else if (valid) begin
            if (start) begin
                cur     <= sample;
                run_len <= 4'd1;
            end else if (track) begin
                if (!match) begin
                    run_len <= '0;
                end else if (in_run) begin
                    run_len <= len_inc;
                end else begin
                    cur     <= cur_nxt;
                    run_len <= 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rep_seq_checker.sv
// Receive-side checker for repeated-value count streams. Aligns to run
// boundaries, reports completed runs, declares lock and counts violations.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | after reset, no sample seen yet
// ST_HUNT   | searching for a run boundary (value change)
// ST_SYNC   | tracking runs, not yet locked
// ST_LOCKED | tracking runs, LOCK_RUNS good runs in a row
module rep_seq_checker
    import seq_chk_pkg::*;
#(
    parameter int W         = 4,
    parameter int REP       = 5,
    parameter int MAXV      = 11,
    parameter int LOCK_RUNS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 locked,
    output logic                 run_done,
    output logic [W-1:0]         run_value,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [W-1:0] MAXV_L = W'(MAXV);
    localparam logic [3:0]   LOCK_L = 4'(LOCK_RUNS);

    seq_state_t   state;
    logic [W-1:0] last;
    logic [3:0]   good_runs;
    logic [3:0]   good_base;
    logic [3:0]   good_inc;
    logic         in_range;
    logic         start;
    logic         track;
    logic         complete;
    logic         violate;
    logic [W-1:0] done_value;

    assign in_range = (in_data <= MAXV_L);
    // HUNT only trusts a value change as a run boundary.
    assign start    = ((state == ST_IDLE) && in_range) ||
                      ((state == ST_HUNT) && in_range && (in_data != last));
    assign track    = (state == ST_SYNC) || (state == ST_LOCKED);

    // A freshly started run counts from zero good runs.
    assign good_base = start ? 4'd0 : good_runs;
    assign good_inc  = (good_base == 4'hF) ? good_base : good_base + 4'd1;

    rep_run_tracker #(
        .W    (W),
        .REP  (REP),
        .MAXV (MAXV)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .valid      (in_valid),
        .start      (start),
        .track      (track),
        .sample     (in_data),
        .complete   (complete),
        .violate    (violate),
        .done_value (done_value)
    );

    // State, lock, run reporting and error counting; everything holds when in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= '0;
            good_runs <= '0;
            locked    <= 1'b0;
            run_done  <= 1'b0;
            run_value <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            run_done  <= 1'b0;
            err_pulse <= 1'b0;
            if (in_valid) begin
                last <= in_data;
                if (violate) begin
                    err_pulse <= 1'b1;
                    err_cnt   <= err_cnt_inc(err_cnt);
                    good_runs <= '0;
                    locked    <= 1'b0;
                    state     <= ST_HUNT;
                end else if (complete) begin
                    run_done  <= 1'b1;
                    run_value <= done_value;
                    good_runs <= good_inc;
                    if ((good_inc >= LOCK_L) || (state == ST_LOCKED)) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                    end else begin
                        state <= ST_SYNC;
                    end
                end else if (start) begin
                    good_runs <= '0;
                    state     <= ST_SYNC;
                end else if (state == ST_IDLE) begin
                    state <= ST_HUNT;
                end
            end
        end
    end

endmodule

// File: doc/rep_seq_checker.md
# rep_seq_checker

Receive-side checker for the repeated-value count stream produced by the team's repeat counters, where each value appears REP times, then increments, wrapping after MAXV, e.g. 0,0,0,0,0,1,1,1,1,1,…,11×5,0…. It samples a qualified input stream, aligns to run boundaries, and reports completed runs. It declares lock after LOCK_RUNS consecutive good runs and flags every sequence violation. It sits downstream of a counter or link under test as a self-checking monitor.

## Interface
- W, default 4: data width.
- REP, default 5: samples per value; legal range 1..15.
- MAXV, default 11: last value before wrap to 0; must satisfy MAXV < 2^W.
- LOCK_RUNS, default 2: consecutive completed runs required for lock; legal range 1..15.
- clk  in  1: single clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: qualifies in_data for this cycle.
- in_data  in  W: stream sample.
- locked  out  1: checker is in LOCKED state.
- run_done  out  1: 1-cycle pulse; a run of REP equal samples has completed.
- run_value  out  W: value of the most recently completed run.
- err_pulse  out  1: 1-cycle pulse; sequence violation.
- err_cnt  out  8: error count, saturates at 255.

## Operation
- States:
  - IDLE: after reset, no sample seen yet.
  - HUNT: searching for a run boundary.
  - SYNC: tracking runs, not yet locked.
  - LOCKED: tracking runs, lock declared.
- Internal registers:
  - cur: W bits, value of the current run.
  - run_len: 4 bits, samples seen in the current run.
  - good_runs: 4 bits, consecutive completed runs.
  - last: W bits, previous sample.
- Registers update only on cycles with in_valid=1. When in_valid=0, all state holds and both pulses are 0.
- nxt(v) = (v==MAXV) ? 0 : v+1, computed in W bits.
- IDLE: the first valid sample with in_data ≤ MAXV starts a run: cur=in_data, run_len=1, go to SYNC. A sample > MAXV is held as last and the state moves to HUNT.
- HUNT: a sample that differs from last and is ≤ MAXV starts a run: cur=sample, run_len=1, good_runs=0, go to SYNC. Any other sample only updates last.
- SYNC/LOCKED, checking each valid sample s:
  - If run_len<REP, s must equal cur; on a match, run_len++.
  - If run_len==REP, s must equal nxt(cur); on a match, cur=nxt(cur) and run_len=1.
- Run completion: when run_len reaches REP (including REP=1, on the starting sample), pulse run_done, set run_value=cur, and increment good_runs, saturating. When good_runs reaches LOCK_RUNS, enter LOCKED.
- Violation in SYNC or LOCKED:
  - Pulse err_pulse and increment err_cnt, saturating at 255.
  - Clear good_runs, set last=s, go to HUNT. locked falls.
  - No run_done is issued on that sample.
- last is updated on every valid sample in every state.
- A run that is too long, i.e. the (REP+1)-th equal sample, is a violation. A run that is too short, i.e. a changed value before REP samples, is also a violation.

## Timing
- All outputs are registered. run_done, run_value, err_pulse, locked and err_cnt reflect sample k in the cycle after the clk edge that captures sample k.
- Reset values: locked=0, run_done=0, run_value=0, err_pulse=0, err_cnt=0, state=IDLE, cur/run_len/good_runs/last=0.
- rst has priority over in_valid. Reset mid-run discards all progress; the next valid sample is handled as in IDLE.
- run_done and err_pulse are never asserted together.
- Throughput: one sample per cycle. Gaps in in_valid of any length do not affect the result.

## Structure
- Shared package (seq_chk_pkg): the state enum (IDLE, HUNT, SYNC, LOCKED) and err_cnt width/saturation constant; reused by future stream monitors.
- One sub-module is natural: rep_run_tracker, which owns cur/run_len/nxt and emits match/complete/violate. The top-level FSM handles state, lock and error counting.

## Test plan
All scenarios use REP=5, MAXV=11, LOCK_RUNS=2.
- Reset, then feed 0×5, 1×5 → run_done after the 5th sample (run_value=0) and after the 10th (run_value=1). locked=1 the cycle after the 10th. err_cnt=0.
- Locked stream 10×5, 11×5, 0×5 → run_value sequence 10, 11, 0. No err_pulse at the 11→0 wrap.
- Locked, then feed 3,3,3,4 → err_pulse the cycle after the 4, err_cnt=1, locked=0. Then 4,4,5×5,6×5 → HUNT starts a run at 5, and relock follows the 10th sample after the 5.
- Locked, six samples of 7 → err_pulse on the 6th. An extra 8 then starts a new run in SYNC.
- Random in_valid=0 gaps of 0–3 cycles inserted into scenario 1 → identical output sequence. Separately, rst asserted after 3 samples of 2 → all outputs are 0 next cycle, and the following 0×5 gives run_done.
- 300 alternating-value violations → err_cnt saturates at 255 and err_pulse still pulses each time.
